// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg
//   Shared definitions for the three-master Wishbone RAM arbiter:
//   - arb_state_e : arbiter FSM states (IDLE / OWN)
//   - GNT_*       : grant index encoding (0 host, 1 ibus, 2 dbus, 3 none)
//   - CTI_*/BTE_* : Wishbone B3 cycle-type and burst-type encodings
package wb_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    localparam logic [1:0] GNT_HOST = 2'd0;
    localparam logic [1:0] GNT_IBUS = 2'd1;
    localparam logic [1:0] GNT_DBUS = 2'd2;
    localparam logic [1:0] GNT_NONE = 2'd3;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// wb_mem_arbiter_if
//   One Wishbone B3 point-to-point link.
//   Request  (master -> slave): adr, dat_m2s, sel, we, cyc, stb, cti, bte
//   Response (slave -> master): dat_s2m, ack, err
//   modport master : the side that issues cycles
//   modport slave  : the side that terminates cycles
interface wb_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat_m2s;
    logic [DATA_W-1:0] dat_s2m;
    logic [SEL_W-1:0]  sel;
    logic              we;
    logic              cyc;
    logic              stb;
    logic [2:0]        cti;
    logic [1:0]        bte;
    logic              ack;
    logic              err;

    modport master (
        output adr, dat_m2s, sel, we, cyc, stb, cti, bte,
        input  dat_s2m, ack, err
    );

    modport slave (
        input  adr, dat_m2s, sel, we, cyc, stb, cti, bte,
        output dat_s2m, ack, err
    );

endinterface

// File: rtl/wb_arb_prio.sv
// wb_arb_prio
//   Combinational next-grant select. The host (cyc[0]) always wins; between
//   the two CPU ports a single requester wins outright and a tie goes to
//   rr_ptr.
//   cyc      : {m2.cyc, m1.cyc, m0.cyc}
//   rr_ptr   : CPU port favoured on a tie (GNT_IBUS or GNT_DBUS)
//   gnt_next : index to grant, GNT_NONE when nobody requests
module wb_arb_prio
    import wb_arb_pkg::*;
(
    input  logic [2:0] cyc,
    input  logic [1:0] rr_ptr,
    output logic [1:0] gnt_next
);

    always_comb begin
        // NOTE: default first so every path assigns gnt_next; otherwise a latch is inferred.
        gnt_next = GNT_NONE;
        if (cyc[0]) begin
            gnt_next = GNT_HOST;
        end else if (cyc[1] && cyc[2]) begin
            gnt_next = rr_ptr;
        end else if (cyc[1]) begin
            gnt_next = GNT_IBUS;
        end else if (cyc[2]) begin
            gnt_next = GNT_DBUS;
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter
//   Three-master / one-slave Wishbone B3 arbiter in front of the program/data
//   RAM. Host loader (m0) has fixed top priority; CPU ibus (m1) and dbus (m2)
//   share round-robin. A grant is held for the whole cyc burst.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   m0, m1, m2    : master-facing links (slave modport)
//   s             : RAM-facing link (master modport)
//   gnt_o         : granted master index, 3 = none
//   Optional: define WB_ARB_TIMEOUT_EN to add a stall watchdog that answers a
//   stuck beat with err after TIMEOUT_CYCLES (1..255) cycles.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    wb_mem_arbiter_if.slave         m0,
    wb_mem_arbiter_if.slave         m1,
    wb_mem_arbiter_if.slave         m2,
    wb_mem_arbiter_if.master        s,
    output logic [1:0]              gnt_o
);

    localparam int unsigned SEL_W = DATA_W / 8;

    arb_state_e        state;
    logic [1:0]        gnt;
    logic [1:0]        rr_ptr;
    logic [1:0]        gnt_next;
    logic              to_hit;

    logic [ADDR_W-1:0] req_adr;
    logic [DATA_W-1:0] req_dat;
    logic [SEL_W-1:0]  req_sel;
    logic              req_we;
    logic              req_cyc;
    logic              req_stb;
    logic [2:0]        req_cti;
    logic [1:0]        req_bte;

    wb_arb_prio u_prio (
        .cyc      ({m2.cyc, m1.cyc, m0.cyc}),
        .rr_ptr   (rr_ptr),
        .gnt_next (gnt_next)
    );

    // Grant FSM. rr_ptr flips to the other CPU port only when a CPU grant is
    // released; a host release leaves it alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ST_IDLE;
            gnt    <= GNT_NONE;
            rr_ptr <= GNT_IBUS;
        end else begin
            // NOTE: non-blocking so every branch sees the pre-edge gnt/rr_ptr.
            case (state)
                ST_IDLE: begin
                    if (gnt_next != GNT_NONE) begin
                        gnt   <= gnt_next;
                        state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (!req_cyc) begin
                        state <= ST_IDLE;
                        gnt   <= GNT_NONE;
                        if (gnt == GNT_IBUS) begin
                            rr_ptr <= GNT_DBUS;
                        end else if (gnt == GNT_DBUS) begin
                            rr_ptr <= GNT_IBUS;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= GNT_NONE;
                end
            endcase
        end
    end

    // Request mux straight off the registered grant: no added beat latency,
    // and an async reset drops the slave request without waiting for a clock.
    always_comb begin
        req_adr = '0;
        req_dat = '0;
        req_sel = '0;
        req_we  = 1'b0;
        req_cyc = 1'b0;
        req_stb = 1'b0;
        req_cti = CTI_CLASSIC;
        req_bte = BTE_LINEAR;
        case (gnt)
            GNT_HOST: begin
                req_adr = m0.adr;  req_dat = m0.dat_m2s; req_sel = m0.sel;
                req_we  = m0.we;   req_cyc = m0.cyc;     req_stb = m0.stb;
                req_cti = m0.cti;  req_bte = m0.bte;
            end
            GNT_IBUS: begin
                req_adr = m1.adr;  req_dat = m1.dat_m2s; req_sel = m1.sel;
                req_we  = m1.we;   req_cyc = m1.cyc;     req_stb = m1.stb;
                req_cti = m1.cti;  req_bte = m1.bte;
            end
            GNT_DBUS: begin
                req_adr = m2.adr;  req_dat = m2.dat_m2s; req_sel = m2.sel;
                req_we  = m2.we;   req_cyc = m2.cyc;     req_stb = m2.stb;
                req_cti = m2.cti;  req_bte = m2.bte;
            end
            default: ;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] to_cnt;

    // Counts stalled strobe cycles; the cycle it reaches the limit the strobe
    // is withdrawn and the owner gets err instead of an ack.
    assign to_hit = (to_cnt == 8'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt <= '0;
        end else if (state == ST_IDLE || s.ack || s.err || to_hit) begin
            to_cnt <= '0;
        end else if (req_stb) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    // Keeps the parameter referenced when the watchdog is not built.
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign to_hit             = 1'b0;
`endif

    assign s.adr     = req_adr;
    assign s.dat_m2s = req_dat;
    assign s.sel     = req_sel;
    assign s.we      = req_we;
    assign s.cyc     = req_cyc;
    assign s.stb     = req_stb & ~to_hit;
    assign s.cti     = req_cti;
    assign s.bte     = req_bte;

    assign m0.dat_s2m = s.dat_s2m;
    assign m1.dat_s2m = s.dat_s2m;
    assign m2.dat_s2m = s.dat_s2m;

    assign m0.ack = s.ack & (gnt == GNT_HOST);
    assign m1.ack = s.ack & (gnt == GNT_IBUS);
    assign m2.ack = s.ack & (gnt == GNT_DBUS);

    assign m0.err = (s.err | to_hit) & (gnt == GNT_HOST);
    assign m1.err = (s.err | to_hit) & (gnt == GNT_IBUS);
    assign m2.err = (s.err | to_hit) & (gnt == GNT_DBUS);

    assign gnt_o = gnt;

endmodule

// File: doc/wb_mem_arbiter.md
# wb_mem_arbiter

Three-master, one-slave Wishbone B3 arbiter in front of the on-chip program/data RAM. It shares that RAM between the host loader (master 0) and the CPU instruction and data buses (masters 1 and 2). The host loader has fixed top priority so image download pre-empts any idle CPU request. The two CPU ports are served round-robin, and each grant is held for the whole `cyc` burst.

## Interface
Parameters:
- `ADDR_W`, 32: address width on all ports.
- `DATA_W`, 32: data width; `SEL_W = DATA_W/8`.
- `TIMEOUT_CYCLES`, 255: stall limit, used only when the timeout feature is compiled in. Legal range 1..255.

Ports (clock and reset first; N = 0..2):
- `clk_i`  input  1  system clock; all logic on its rising edge.
- `rst_ni`  input  1  asynchronous active-low reset.
- `mN_adr_i`  input  ADDR_W  master N address.
- `mN_dat_i`  input  DATA_W  master N write data.
- `mN_sel_i`  input  SEL_W  master N byte select.
- `mN_we_i`, `mN_cyc_i`, `mN_stb_i`  input  1 each  master N control.
- `mN_cti_i`  input  3  master N cycle type; `mN_bte_i`  input  2  master N burst type.
- `mN_dat_o`  output  DATA_W  read data to master N.
- `mN_ack_o`, `mN_err_o`  output  1 each  termination to master N.
- `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_we_o`, `s_cyc_o`, `s_stb_o`, `s_cti_o`, `s_bte_o`  output  as above  slave request.
- `s_dat_i`  input  DATA_W  slave read data.
- `s_ack_i`, `s_err_i`  input  1 each  slave termination.
- `gnt_o`  output  2  granted master index; 3 = none (debug).

## Operation
- FSM states: `IDLE` and `OWN`. The grant register `gnt` is cleared to 3 on reset.
- `IDLE`:
  - If `m0_cyc_i`, grant 0.
  - Otherwise, if exactly one of `m1_cyc_i`/`m2_cyc_i` is high, grant that master.
  - If both are high, grant the one selected by `rr_ptr` (1 or 2; reset value 1).
  - On any grant, go to `OWN`.
- `OWN`: the master named by `gnt` drives all `s_*` outputs. `s_cyc_o` and `s_stb_o` are that master's `cyc`/`stb`. When the granted master drops `cyc`, return to `IDLE` and set `gnt` to 3.
- Round-robin: when a CPU grant (1 or 2) is released, `rr_ptr` points to the other CPU port. Releasing master 0 leaves `rr_ptr` unchanged.
- No pre-emption inside `OWN`. A host request raised during a CPU burst waits for that burst's `cyc` to drop.
- Return path:
  - `s_dat_i` fans out to every `mN_dat_o` unconditionally.
  - `mN_ack_o = s_ack_i & (gnt==N)`.
  - `mN_err_o = s_err_i & (gnt==N)`, ORed with the timeout error when that feature is present.
- When `gnt==3`, all `s_*` outputs are 0.

## Timing
- Reset values: `gnt_o`=3, `rr_ptr`=1; every `s_*` output, `mN_ack_o` and `mN_err_o` are 0.
- Arbitration latency: `cyc` is sampled in `IDLE` at edge k, `gnt` is valid after edge k, and `s_cyc_o` is high during cycle k+1. First access costs 1 extra cycle.
- Request and response muxes are combinational from registered `gnt`. The arbiter adds zero latency per beat inside a burst.
- Release: `cyc` low at edge k gives `IDLE` after k. The next grant is made at edge k+1, so there is one idle cycle between owners.
- Simultaneous requests: master 0 beats CPU ports; the tie between CPU ports goes to `rr_ptr`.
- Asynchronous reset mid-burst clears `gnt` immediately and forces `s_cyc_o`/`s_stb_o` low. The slave sees an aborted cycle.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter increments each cycle with `s_stb_o` high and both `s_ack_i` and `s_err_i` low.
  - It clears on `s_ack_i`, `s_err_i` or `IDLE`.
  - When it reaches `TIMEOUT_CYCLES`, the granted master receives a one-cycle `mN_err_o`, `s_stb_o` is masked that cycle, and the counter clears. The grant is kept until that master drops `cyc`.
- Undefined: no counter exists, and `mN_err_o` is purely the gated `s_err_i`.

## Structure
- Shared package `wb_arb_pkg`: FSM state enum, grant index constants (`GNT_HOST`=0, `GNT_IBUS`=1, `GNT_DBUS`=2, `GNT_NONE`=3), and the Wishbone `cti`/`bte` constants.
- Sub-module `wb_arb_prio`: combinational priority/round-robin select taking the three `cyc` inputs and `rr_ptr` and returning the next grant. The top level holds the FSM, the muxes and the optional timeout counter.

## Test plan
- Reset, then `m1_cyc_i`/`m1_stb_i` raised with adr=0x100: `s_cyc_o` rises 1 cycle later with `s_adr_o`=0x100. `s_ack_i` then gives `m1_ack_o`=1 and `m0_ack_o`=`m2_ack_o`=0.
- m1 and m2 both request continuously with single-beat cycles: grants alternate 1,2,1,2, with one idle cycle between owners.
- m0 requests during an m2 4-beat burst: m2 finishes all 4 acks, the next grant is 0, and `rr_ptr` then points to 1.
- Host write adr=0x0, data=0xDEADBEEF, sel=0xF, we=1: the slave sees exactly those values and `m0_ack_o` pulses once.
- `rst_ni` asserted mid-burst: `s_cyc_o`=0 and `gnt_o`=3 without waiting for a clock edge.
- With `WB_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, slave never acks: `m1_err_o` pulses after 4 stalled cycles, and `mN_err_o` is never set without the macro.
